ifu_fetch: RTL and testbench

- Instruction fetch unit. Sits directly upstream of the IF/ID pipeline register.
- Owns the architectural fetch PC and issues one read at a time to instruction memory over an AXI-lite-style AR/R channel.
- Presents {inst, pc} to IF/ID with a valid/ready handshake.
- Accepts redirects (branch/jump/trap) from the back end and discards any wrong-path fetch.

---
 rtl/ifu_fetch_pkg.sv | 15 +
 rtl/ifu_fetch.sv | 97 +++++++++
 tb/tb_ifu_fetch.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ifu_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM states, response codes
// and the default boot PC.
package ifu_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD
    } ifu_state_e;

    localparam logic [1:0]  RESP_OKAY        = 2'b00;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

endpackage

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the fetch PC, issues one AR/R read at a time and
// presents {inst, pc, fault} to IF/ID with a valid/ready handshake.
module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter int              PC_W     = 32,
    parameter int              INST_W   = 32,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEFAULT)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              redirect_valid_i,
    input  logic [PC_W-1:0]   redirect_pc_i,
    output logic              imem_arvalid_o,
    output logic [PC_W-1:0]   imem_araddr_o,
    input  logic              imem_arready_i,
    input  logic              imem_rvalid_i,
    input  logic [INST_W-1:0] imem_rdata_i,
    input  logic [1:0]        imem_rresp_i,
    output logic              imem_rready_o,
    output logic [INST_W-1:0] f_inst_o,
    output logic [PC_W-1:0]   f_pc_o,
    output logic              f_fault_o,
    output logic              f_valid_o,
    input  logic              D_ready_i
);

    ifu_state_e        state, state_d;
    logic [PC_W-1:0]   pc, pc_d;
    logic [PC_W-1:0]   addr_q;
    logic              kill, kill_d;
    logic [INST_W-1:0] inst_q;
    logic              fault_q;
    logic              accept;

    assign accept = (state == HOLD) && !redirect_valid_i && D_ready_i;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        state_d = state;
        pc_d    = pc;
        kill_d  = kill;
        case (state)
            IDLE: state_d = REQ;
            REQ: begin
                if (redirect_valid_i) kill_d = 1'b1;
                if (imem_arready_i)   state_d = WAIT;
            end
            WAIT: begin
                if (imem_rvalid_i) begin
                    kill_d  = 1'b0;
                    state_d = (kill || redirect_valid_i) ? REQ : HOLD;
                end else if (redirect_valid_i) begin
                    kill_d = 1'b1;
                end
            end
            HOLD: if (redirect_valid_i || D_ready_i) state_d = REQ;
            default: state_d = IDLE;
        endcase
        if (redirect_valid_i)  pc_d = redirect_pc_i;
        else if (accept)       pc_d = pc + PC_W'(32'd4);
    end

    always_comb begin
        imem_arvalid_o = (state == REQ);
        imem_araddr_o  = (state == REQ) ? addr_q : pc;
        imem_rready_o  = (state == WAIT);
        f_valid_o      = (state == HOLD) && !redirect_valid_i;
        f_inst_o       = (state == HOLD) ? inst_q : '0;
        f_fault_o      = (state == HOLD) && fault_q;
        f_pc_o         = pc;
    end

    // addr_q freezes while AR is open, so a redirect in REQ cannot move the address.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= IDLE;
            pc     <= RESET_PC;
            addr_q <= RESET_PC;
            kill   <= 1'b0;
        end else begin
            state <= state_d;
            pc    <= pc_d;
            kill  <= kill_d;
            if (state != REQ) addr_q <= pc_d;
        end
    end

    // NOTE: inst_q/fault_q carry no reset; they are only observed in HOLD, after a load.
    always_ff @(posedge clk_i) begin
        if (state == WAIT && imem_rvalid_i) begin
            inst_q  <= imem_rdata_i;
            fault_q <= (imem_rresp_i != RESP_OKAY);
        end
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: directed vector table, hand-written corner
// sequences, and a randomized phase scored against a packet-level PC model.
module tb_ifu_fetch;

    localparam logic [31:0] A0   = 32'h8000_0000;
    localparam logic [31:0] A4   = 32'h8000_0004;
    localparam logic [31:0] A8   = 32'h8000_0008;
    localparam logic [31:0] AC   = 32'h8000_000C;
    localparam logic [31:0] B0   = 32'h8000_0010;
    localparam logic [31:0] A100 = 32'h8000_0100;
    localparam logic [31:0] A200 = 32'h8000_0200;
    localparam logic [31:0] A300 = 32'h8000_0300;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        arvalid, rready, f_fault, f_valid;
    logic [31:0] araddr, f_inst, f_pc;
    logic        arready = 1'b0;
    logic        rvalid = 1'b0;
    logic [31:0] rdata = '0;
    logic [1:0]  rresp = '0;
    logic        d_ready = 1'b0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ifu_fetch #(.RESET_PC(A0)) dut (
        .clk_i(clk), .rst_i(rst),
        .redirect_valid_i(redirect_valid), .redirect_pc_i(redirect_pc),
        .imem_arvalid_o(arvalid), .imem_araddr_o(araddr), .imem_arready_i(arready),
        .imem_rvalid_i(rvalid), .imem_rdata_i(rdata), .imem_rresp_i(rresp),
        .imem_rready_o(rready),
        .f_inst_o(f_inst), .f_pc_o(f_pc), .f_fault_o(f_fault), .f_valid_o(f_valid),
        .D_ready_i(d_ready)
    );

    typedef struct {
        logic        dr, ar, rv;
        logic [31:0] rd;
        logic [1:0]  resp;
        logic        av;
        logic [31:0] aa;
        logic        rr, fv;
        logic [31:0] fp, fi;
        logic        ff;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(input logic dr, input logic ar, input logic rv,
                               input logic [31:0] rd, input logic [1:0] resp,
                               input logic av, input logic [31:0] aa, input logic rr,
                               input logic fv, input logic [31:0] fp,
                               input logic [31:0] fi, input logic ff);
        vec_t t;
        t.dr = dr; t.ar = ar; t.rv = rv; t.rd = rd; t.resp = resp;
        t.av = av; t.aa = aa; t.rr = rr; t.fv = fv; t.fp = fp; t.fi = fi; t.ff = ff;
        return t;
    endfunction

    // Memory contents and fault map used by the randomized slave and the model.
    function automatic logic [31:0] word(input logic [31:0] a);
        return {a[15:0], 16'h0013};
    endfunction

    function automatic logic is_fault(input logic [31:0] a);
        return a[5:2] == 4'hB;
    endfunction

    function automatic logic [127:0] pack(input logic av, input logic [31:0] aa,
                                          input logic rr, input logic fv,
                                          input logic [31:0] fp, input logic [31:0] fi,
                                          input logic ff);
        return {28'b0, av, aa, rr, fv, fp, fi, ff};
    endfunction

    function automatic logic [127:0] outs();
        return {28'b0, arvalid, araddr, rready, f_valid, f_pc, f_inst, f_fault};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // One clock cycle: drive inputs just after the falling edge, sample 1 unit later.
    task automatic cyc(input logic rd, input logic [31:0] rpc, input logic dr,
                       input logic ar, input logic rv, input logic [31:0] data,
                       input logic [1:0] resp);
        @(negedge clk);
        rst = 1'b0;
        redirect_valid = rd; redirect_pc = rpc; d_ready = dr;
        arready = ar; rvalid = rv; rdata = data; rresp = resp;
        #1;
    endtask

    // Leaves reset asserted; the next cyc() call is the IDLE cycle.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        redirect_valid = 1'b0; redirect_pc = '0; d_ready = 1'b0;
        arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = '0;
        @(negedge clk);
        #1;
        check("reset_outputs", outs(), pack(1'b0, A0, 1'b0, 1'b0, A0, 32'h0, 1'b0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic        r_pend, prev_ar_stall, prev_hold;
    logic [31:0] r_addr, prev_araddr, model_pc;
    logic [64:0] prev_pkt;
    int          r_hold, ar_hold, accepted;

    initial begin
        // Zero-wait fetch from reset, then a faulting fetch at 0x8000_0008.
        //           dr    ar    rv    rdata          resp   av    araddr rr    fv    f_pc  f_inst         ff
        tbl.push_back(v(1'b1, 1'b1, 1'b0, 32'h0,         2'b00, 1'b0, A0, 1'b0, 1'b0, A0, 32'h0,         1'b0));
        tbl.push_back(v(1'b1, 1'b1, 1'b0, 32'h0,         2'b00, 1'b1, A0, 1'b0, 1'b0, A0, 32'h0,         1'b0));
        tbl.push_back(v(1'b1, 1'b1, 1'b1, 32'h13,        2'b00, 1'b0, A0, 1'b1, 1'b0, A0, 32'h0,         1'b0));
        tbl.push_back(v(1'b1, 1'b1, 1'b0, 32'h0,         2'b00, 1'b0, A0, 1'b0, 1'b1, A0, 32'h13,        1'b0));
        tbl.push_back(v(1'b1, 1'b1, 1'b0, 32'h0,         2'b00, 1'b1, A4, 1'b0, 1'b0, A4, 32'h0,         1'b0));
        tbl.push_back(v(1'b1, 1'b1, 1'b1, 32'h0004_0013, 2'b00, 1'b0, A4, 1'b1, 1'b0, A4, 32'h0,         1'b0));
        tbl.push_back(v(1'b1, 1'b1, 1'b0, 32'h0,         2'b00, 1'b0, A4, 1'b0, 1'b1, A4, 32'h0004_0013, 1'b0));
        tbl.push_back(v(1'b1, 1'b1, 1'b0, 32'h0,         2'b00, 1'b1, A8, 1'b0, 1'b0, A8, 32'h0,         1'b0));
        tbl.push_back(v(1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF, 2'b10, 1'b0, A8, 1'b1, 1'b0, A8, 32'h0,         1'b0));
        tbl.push_back(v(1'b1, 1'b1, 1'b0, 32'h0,         2'b00, 1'b0, A8, 1'b0, 1'b1, A8, 32'hDEAD_BEEF, 1'b1));
        tbl.push_back(v(1'b1, 1'b1, 1'b0, 32'h0,         2'b00, 1'b1, AC, 1'b0, 1'b0, AC, 32'h0,         1'b0));
        tbl.push_back(v(1'b1, 1'b1, 1'b1, 32'h0000_6F00, 2'b00, 1'b0, AC, 1'b1, 1'b0, AC, 32'h0,         1'b0));
        tbl.push_back(v(1'b1, 1'b1, 1'b0, 32'h0,         2'b00, 1'b0, AC, 1'b0, 1'b1, AC, 32'h0000_6F00, 1'b0));
        tbl.push_back(v(1'b1, 1'b0, 1'b0, 32'h0,         2'b00, 1'b1, B0, 1'b0, 1'b0, B0, 32'h0,         1'b0));

        do_reset();
        foreach (tbl[i]) begin
            cyc(1'b0, 32'h0, tbl[i].dr, tbl[i].ar, tbl[i].rv, tbl[i].rd, tbl[i].resp);
            check($sformatf("vec%0d", i), outs(),
                  pack(tbl[i].av, tbl[i].aa, tbl[i].rr, tbl[i].fv, tbl[i].fp, tbl[i].fi, tbl[i].ff));
        end

        // IF/ID stalls for 5 cycles in HOLD.
        do_reset();
        cyc(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0, 2'b00);
        cyc(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0, 2'b00);
        cyc(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h13, 2'b00);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 2'b00);
            check($sformatf("stall_hold%0d", i), 128'({f_valid, f_pc, f_inst, arvalid}),
                  128'({1'b1, A0, 32'h13, 1'b0}));
        end
        cyc(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0, 2'b00);
        check("stall_release", 128'({f_valid, f_pc}), 128'({1'b1, A0}));
        cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 2'b00);
        check("stall_next_ar", 128'({arvalid, araddr}), 128'({1'b1, A4}));

        // arready held off for 4 cycles, redirect on the second REQ cycle.
        do_reset();
        cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 2'b00);
        cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 2'b00);
        check("ar_wait0", 128'({arvalid, araddr}), 128'({1'b1, A0}));
        cyc(1'b1, A100, 1'b1, 1'b0, 1'b0, 32'h0, 2'b00);
        check("ar_redirect", 128'({arvalid, araddr, f_valid}), 128'({1'b1, A0, 1'b0}));
        for (int i = 0; i < 2; i++) begin
            cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 2'b00);
            check($sformatf("ar_held%0d", i), 128'({arvalid, araddr}), 128'({1'b1, A0}));
        end
        cyc(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0, 2'b00);
        check("ar_accept_old", 128'({arvalid, araddr}), 128'({1'b1, A0}));
        cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h13, 2'b00);
        check("killed_data", 128'({rready, f_valid}), 128'({1'b1, 1'b0}));
        cyc(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0, 2'b00);
        check("refetch", 128'({arvalid, araddr, f_valid}), 128'({1'b1, A100, 1'b0}));
        cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, word(A100), 2'b00);
        cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 2'b00);
        check("redirect_pkt", 128'({f_valid, f_pc, f_inst}), 128'({1'b1, A100, word(A100)}));

        // Redirect in HOLD while IF/ID is ready.
        do_reset();
        cyc(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0, 2'b00);
        cyc(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0, 2'b00);
        cyc(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h13, 2'b00);
        cyc(1'b1, A200, 1'b1, 1'b1, 1'b0, 32'h0, 2'b00);
        check("hold_redirect_mask", 128'(f_valid), 128'(1'b0));
        cyc(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0, 2'b00);
        check("hold_redirect_ar", 128'({arvalid, araddr}), 128'({1'b1, A200}));
        cyc(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, word(A200), 2'b00);
        cyc(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0, 2'b00);
        check("hold_redirect_pkt", 128'({f_valid, f_pc, f_inst}), 128'({1'b1, A200, word(A200)}));

        // Redirect in the same cycle as rvalid.
        do_reset();
        cyc(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0, 2'b00);
        cyc(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0, 2'b00);
        cyc(1'b1, A300, 1'b1, 1'b1, 1'b1, 32'h13, 2'b00);
        check("wait_redirect_drop", 128'({rready, f_valid}), 128'({1'b1, 1'b0}));
        cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 2'b00);
        check("wait_redirect_ar", 128'({arvalid, araddr, f_valid}), 128'({1'b1, A300, 1'b0}));

        // Redirect in IDLE to the top of the address space; pc+4 wraps to 0.
        do_reset();
        cyc(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1, 1'b0, 32'h0, 2'b00);
        cyc(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0, 2'b00);
        check("wrap_ar", 128'({arvalid, araddr}), 128'({1'b1, 32'hFFFF_FFFC}));
        cyc(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h13, 2'b00);
        cyc(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0, 2'b00);
        check("wrap_pkt", 128'({f_valid, f_pc}), 128'({1'b1, 32'hFFFF_FFFC}));
        cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 2'b00);
        check("wrap_next_ar", 128'({arvalid, araddr}), 128'({1'b1, 32'h0}));

        // Reset while a read is open, then restart from RESET_PC.
        do_reset();
        cyc(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0, 2'b00);
        cyc(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0, 2'b00);
        cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 2'b00);
        do_reset();
        cyc(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0, 2'b00);
        check("midreset_idle", 128'({arvalid, rready, f_valid}), 128'(3'b000));
        cyc(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0, 2'b00);
        check("midreset_ar", 128'({arvalid, araddr}), 128'({1'b1, A0}));

        // Randomized traffic: the accepted packet stream must follow the PC model.
        do_reset();
        r_pend = 1'b0; r_addr = '0; r_hold = 0; ar_hold = 0;
        prev_ar_stall = 1'b0; prev_araddr = '0; prev_hold = 1'b0; prev_pkt = '0;
        model_pc = A0; accepted = 0;
        for (int n = 0; n < 3000; n++) begin
            logic        rd;
            logic [31:0] rpc;
            rd  = ($urandom_range(0, 9) == 0);
            rpc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8
                                              : A0 + 32'($urandom_range(0, 255) << 2);
            cyc(rd, rpc, ($urandom_range(0, 3) != 0), (ar_hold == 0), (r_pend && r_hold == 0),
                r_pend ? word(r_addr) : 32'h0,
                (r_pend && is_fault(r_addr)) ? 2'b10 : 2'b00);

            if (rd) check("rand_mask", 128'(f_valid), 128'(1'b0));
            if (f_valid && d_ready) begin
                check("rand_pkt", 128'({f_pc, f_inst, f_fault}),
                      128'({model_pc, word(model_pc), is_fault(model_pc)}));
                model_pc = model_pc + 32'd4;
                accepted++;
            end
            if (rd) model_pc = rpc;
            if (prev_ar_stall)
                check("rand_ar_stable", 128'({arvalid, araddr}), 128'({1'b1, prev_araddr}));
            if (arvalid) check("rand_one_outstanding", 128'(r_pend), 128'(1'b0));
            if (prev_hold)
                check("rand_hold_stable", 128'({f_valid, f_pc, f_inst, f_fault}),
                      128'({~rd, prev_pkt}));

            prev_ar_stall = arvalid && !arready;
            prev_araddr   = araddr;
            prev_hold     = f_valid && !d_ready;
            prev_pkt      = {f_pc, f_inst, f_fault};

            if (rvalid && rready)        r_pend = 1'b0;
            else if (r_pend && r_hold > 0) r_hold--;
            if (arvalid && arready) begin
                r_pend  = 1'b1;
                r_addr  = araddr;
                r_hold  = int'($urandom_range(0, 2));
                ar_hold = int'($urandom_range(0, 3));
            end else if (arvalid && ar_hold > 0) begin
                ar_hold--;
            end
        end
        check("rand_progress", 128'(accepted > 50), 128'(1'b1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
